pcileech_tx_arbiter: RTL and testbench



---
 rtl/pcileech_tx_arb_pkg.sv | 41 ++++
 rtl/pcileech_skid_buf.sv | 73 +++++++
 rtl/pcileech_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_pcileech_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_tx_arb_pkg
// Brief    : Shared types and the round-robin pick helper for the TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pcileech_tx_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

    localparam int ARB_NUM_SRC = 4;

    localparam logic [1:0] ARB_SRC_DATA   = 2'd0;
    localparam logic [1:0] ARB_SRC_CFG    = 2'd1;
    localparam logic [1:0] ARB_SRC_CORE   = 2'd2;
    localparam logic [1:0] ARB_SRC_SHADOW = 2'd3;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  src;
        logic        last;
    } arb_beat_t;

    // First set bit of elig at or above ptr, wrapping modulo ARB_NUM_SRC.
    function automatic logic [1:0] arb_rr_pick(input logic [ARB_NUM_SRC-1:0] elig,
                                               input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        arb_rr_pick = ptr;
        found       = 1'b0;
        for (int k = 0; k < ARB_NUM_SRC; k++) begin
            idx = ptr + k[1:0];
            if (!found && elig[idx]) begin
                arb_rr_pick = idx;
                found       = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcileech_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_skid_buf
// Brief    : 2-entry ready/valid buffer; registered outputs, in_ready from occupancy only.
// Revision : 1.0 - initial release
// ============================================================================
module pcileech_skid_buf
    import pcileech_tx_arb_pkg::*;
#(
    parameter int WIDTH = $bits(arb_beat_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             head_valid_q, head_valid_d;
    logic             tail_valid_q, tail_valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push, pop;

    always_comb begin
        head_valid_d = head_valid_q;
        tail_valid_d = tail_valid_q;
        head_d       = head_q;
        tail_d       = tail_q;
        push         = in_valid & ~tail_valid_q;
        pop          = head_valid_q & out_ready;
        if (tail_valid_q) begin
            // Full: no push possible, tail slides into head on pop.
            if (pop) begin
                head_d       = tail_q;
                tail_valid_d = 1'b0;
            end
        end else if (head_valid_q && !pop) begin
            if (push) begin
                tail_d       = in_data;
                tail_valid_d = 1'b1;
            end
        end else begin
            head_valid_d = push;
            if (push) begin
                head_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            tail_valid_q <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            tail_valid_q <= tail_valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
        end
    end

    assign in_ready  = ~tail_valid_q;
    assign out_valid = head_valid_q;
    assign out_data  = head_q;

endmodule
`default_nettype wire

// File: rtl/pcileech_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_tx_arbiter
// Brief    : Packet-atomic round-robin arbiter of four sources with stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module pcileech_tx_arbiter
    import pcileech_tx_arb_pkg::*;
#(
    parameter int PARAM_TIMEOUT   = 1024,
    parameter int PARAM_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 src_en,
    input  logic [3:0]                 src_valid,
    input  logic [127:0]               src_data,
    input  logic [3:0]                 src_last,
    output logic [3:0]                 src_ready,
    output logic [31:0]                out_data,
    output logic [1:0]                 out_src,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [PARAM_CNT_WIDTH-1:0] pkt_count
);

    localparam int                  STARVE_W   = $clog2(PARAM_TIMEOUT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(PARAM_TIMEOUT - 1);

    arb_state_e                 state_q, state_d;
    logic [1:0]                 grant_q, grant_d;
    logic [1:0]                 ptr_q, ptr_d;
    logic [STARVE_W-1:0]        starve_q, starve_d;
    logic                       timeout_err_q, timeout_err_d;
    logic [PARAM_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

    logic [3:0] elig;
    logic       beat_acc;
    logic       skid_in_valid;
    logic       skid_in_ready;
    arb_beat_t  skid_in;
    arb_beat_t  skid_out;
    arb_beat_t  src_beat [ARB_NUM_SRC];

    for (genvar i = 0; i < ARB_NUM_SRC; i++) begin : g_src_beat
        assign src_beat[i] = '{data: src_data[32*i +: 32], src: 2'(i), last: src_last[i]};
    end

    assign elig = src_en & src_valid;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        starve_d      = starve_q;
        pkt_count_d   = pkt_count_q;
        timeout_err_d = 1'b0;
        src_ready     = '0;
        skid_in_valid = 1'b0;
        beat_acc      = 1'b0;
        skid_in       = src_beat[grant_q];
        case (state_q)
            ARB_IDLE: begin
                if (|elig) begin
                    grant_d  = arb_rr_pick(elig, ptr_q);
                    ptr_d    = grant_d + 2'd1;
                    starve_d = '0;
                    state_d  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                src_ready[grant_q] = skid_in_ready;
                skid_in_valid      = src_valid[grant_q];
                beat_acc           = src_valid[grant_q] & skid_in_ready;
                if (beat_acc) begin
                    starve_d = '0;
                    if (src_beat[grant_q].last) begin
                        pkt_count_d = pkt_count_q + PARAM_CNT_WIDTH'(1);
                        state_d     = ARB_IDLE;
                    end
                end else if (!src_valid[grant_q]) begin
                    // Only a silent source starves; downstream backpressure never does.
                    if (starve_q == STARVE_MAX) begin
                        state_d       = ARB_IDLE;
                        timeout_err_d = 1'b1;
                    end else begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            ptr_q         <= '0;
            starve_q      <= '0;
            timeout_err_q <= 1'b0;
            pkt_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
            starve_q      <= starve_d;
            timeout_err_q <= timeout_err_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    pcileech_skid_buf #(
        .WIDTH($bits(arb_beat_t))
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (skid_in_valid),
        .in_ready (skid_in_ready),
        .in_data  (skid_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (skid_out)
    );

    assign out_data    = skid_out.data;
    assign out_src     = skid_out.src;
    assign out_last    = skid_out.last;
    assign busy        = (state_q == ARB_GRANT);
    assign timeout_err = timeout_err_q;
    assign pkt_count   = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pcileech_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcileech_tx_arbiter
// Brief    : Directed and randomized checks of the TX arbiter against a packet-order model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcileech_tx_arbiter;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   src_en = '0, src_valid = '0, src_last = '0;
    logic [127:0] src_data = '0;
    logic         out_ready = 1'b0;
    logic [3:0]   src_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         out_last, out_valid, busy, timeout_err;
    logic [15:0]  pkt_count;

    pcileech_tx_arbiter #(.PARAM_TIMEOUT(TO), .PARAM_CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .src_en(src_en), .src_valid(src_valid),
        .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
        .out_data(out_data), .out_src(out_src), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .timeout_err(timeout_err), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_fail = 0, cyc = 0, first_v = -1, rdy_mode = 0, np = 0;
    logic [32:0] srcq [4][$];
    logic [34:0] expq [$];
    int          outcyc [$];
    bit          midpkt [4];
    int          gapcnt [4];
    int          src_seen [4];
    bit          gaps_on = 1'b0;
    bit          have_prev = 1'b0, prev_v, prev_r, prev_l;
    logic [31:0] prev_d;
    logic [1:0]  prev_s;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_src(input int s, input logic [31:0] d, input logic l);
        src_data[32*s +: 32] = d;
        src_last[s]          = l;
    endtask

    task automatic add_beat(input int s, input logic [31:0] d, input logic l);
        srcq[s].push_back({l, d});
    endtask

    task automatic add_pkt(input int s, input int len);
        for (int j = 0; j < len; j++) srcq[s].push_back({(j == len - 1), 32'($urandom)});
    endtask

    // Reference: with every pending source presenting valid between packets, the
    // output is whole packets taken round-robin among enabled non-empty sources.
    function automatic int build_exp(input logic [3:0] en);
        logic [32:0] q [4][$];
        logic [32:0] b;
        int p = 0, n = 0, g;
        for (int i = 0; i < 4; i++) q[i] = srcq[i];
        expq.delete();
        for (int it = 0; it < 1000; it++) begin
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && en[(p + k) % 4] && q[(p + k) % 4].size() > 0) g = (p + k) % 4;
            if (g < 0) break;
            do begin
                b = q[g].pop_front();
                expq.push_back({g[1:0], b[32], b[31:0]});
            end while (!b[32]);
            n++;
            p = (g + 1) % 4;
        end
        return n;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        src_valid = '0;
        out_ready = 1'b1;
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_src_ready", src_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            midpkt[i] = 1'b0; gapcnt[i] = 0; src_seen[i] = 0;
        end
        have_prev = 1'b0;
    endtask

    task automatic tick();
        logic [3:0]  v;
        logic [32:0] b;
        logic [34:0] e;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (srcq[i].size() > 0) begin
                if (gaps_on && midpkt[i] && gapcnt[i] < 3 && $urandom_range(0, 3) == 0) gapcnt[i]++;
                else begin
                    v[i]      = 1'b1;
                    gapcnt[i] = 0;
                end
                b = srcq[i][0];
            end else begin
                b = {1'b0, 32'($urandom)};
            end
            set_src(i, b[31:0], b[32]);
        end
        src_valid = v;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = (cyc % 3 == 0);
        endcase
        if (first_v < 0 && |v) first_v = cyc;
        #1;
        if (have_prev && prev_v && !prev_r) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_d);
            chk("hold_src", out_src, prev_s);
            chk("hold_last", out_last, prev_l);
        end
        if (out_valid && out_ready) begin
            e = (expq.size() > 0) ? expq.pop_front() : 'x;
            chk("beat_data", out_data, e[31:0]);
            chk("beat_src", out_src, e[34:33]);
            chk("beat_last", out_last, e[32]);
            src_seen[out_src]++;
            outcyc.push_back(cyc);
        end
        chk("ready_onehot0", $onehot0(src_ready), 1);
        have_prev = 1'b1;
        prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
        prev_s = out_src;   prev_l = out_last;
        for (int i = 0; i < 4; i++) begin
            if (src_valid[i] && src_ready[i]) begin
                b         = srcq[i].pop_front();
                midpkt[i] = !b[32];
            end
        end
        step();
    endtask

    task automatic run_phase(input int budget, input int chg_at, input logic [3:0] en_after);
        int c = 0;
        have_prev = 1'b0;
        outcyc.delete();
        first_v = -1;
        while (expq.size() > 0 && c < budget) begin
            if (c == chg_at) src_en = en_after;
            tick();
            c++;
        end
        chk("drain_left", expq.size(), 0);
        src_valid = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        do_reset();

        // Single source, fixed three-beat packet.
        src_en = 4'hF; rdy_mode = 0; gaps_on = 1'b0;
        add_beat(1, 32'hA0, 1'b0); add_beat(1, 32'hA1, 1'b0); add_beat(1, 32'hA2, 1'b1);
        np = build_exp(4'hF);
        run_phase(100, -1, 4'hF);
        for (int k = 0; k < 3; k++)
            chk("single_latency", (outcyc.size() > k) ? outcyc[k] : -1, first_v + 2 + k);
        chk("single_pkt_count", pkt_count, 1);

        // Reset during beat 2 of a source-2 packet, then ptr must restart at 0.
        out_ready = 1'b1; src_valid = 4'b0100; set_src(2, 32'hB0, 1'b0);
        step();
        chk("rmp_ready2", src_ready, 4'b0100);
        step();
        set_src(2, 32'hB1, 1'b0);
        chk("rmp_cnt_before", pkt_count, 1);
        rst = 1'b1;
        step();
        chk("rmp_out_valid", out_valid, 0);
        chk("rmp_src_ready", src_ready, 0);
        chk("rmp_pkt_count", pkt_count, 0);
        chk("rmp_busy", busy, 0);
        rst = 1'b0; src_valid = 4'b1010;
        set_src(1, 32'hC1, 1'b1); set_src(3, 32'hC3, 1'b1);
        step();
        chk("rmp_grant_lowest", src_ready, 4'b0010);
        src_valid = '0;

        // Round robin with single-beat packets.
        do_reset();
        for (int s = 0; s < 4; s++) for (int k = 0; k < 3; k++) add_pkt(s, 1);
        np = build_exp(4'hF);
        run_phase(200, -1, 4'hF);
        for (int k = 1; k < 12; k++)
            chk("rr_bubble", (outcyc.size() > k) ? outcyc[k] - outcyc[k-1] : -1, 2);
        chk("rr_pkt_count", pkt_count, np);

        // Backpressure 1,0,0 pattern with a competing source.
        do_reset();
        rdy_mode = 2;
        add_pkt(0, 4); add_pkt(2, 3);
        np = build_exp(4'hF);
        run_phase(200, -1, 4'hF);
        chk("bp_pkt_count", pkt_count, np);

        // Watchdog: source 3 stalls mid-packet.
        do_reset();
        src_valid = 4'b1000; set_src(3, 32'h33, 1'b0);
        step();
        chk("wd_ready3", src_ready, 4'b1000);
        step();
        src_valid = 4'b0001; set_src(0, 32'h55, 1'b1);
        chk("wd_beat_data", out_data, 32'h33);
        chk("wd_beat_src", out_src, 3);
        for (int k = 1; k < TO; k++) begin
            step();
            chk("wd_no_err_yet", timeout_err, 0);
            chk("wd_busy_held", busy, 1);
        end
        step();
        chk("wd_err_pulse", timeout_err, 1);
        chk("wd_busy_drop", busy, 0);
        chk("wd_pkt_count", pkt_count, 0);
        step();
        chk("wd_err_one_cycle", timeout_err, 0);
        chk("wd_next_grant0", src_ready, 4'b0001);
        step();
        src_valid = '0;
        chk("wd_src0_done", pkt_count, 1);

        // Enable cleared during a source-0 packet.
        do_reset();
        rdy_mode = 0;
        add_pkt(0, 4); add_pkt(1, 2);
        np = build_exp(4'hF);
        run_phase(200, 2, 4'b1110);
        chk("en_chg_pkt_count", pkt_count, np);

        // Random traffic with source 2 masked off.
        do_reset();
        src_en = 4'b1011; rdy_mode = 1; gaps_on = 1'b1;
        for (int s = 0; s < 4; s++) for (int k = 0; k < 3; k++) add_pkt(s, $urandom_range(1, 4));
        np = build_exp(4'b1011);
        run_phase(3000, -1, 4'b1011);
        chk("mask_src2_seen", src_seen[2], 0);
        chk("mask_pkt_count", pkt_count, np);
        srcq[2].delete();

        // Fully random rounds.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            src_en = 4'hF;
            for (int s = 0; s < 4; s++)
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) add_pkt(s, $urandom_range(1, 6));
            np = build_exp(4'hF);
            run_phase(4000, -1, 4'hF);
            chk("rand_pkt_count", pkt_count, np);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
